// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 serial transmitter among NUM_REQ byte producers.
// A grant drives tx_data/tx_start and waits for the transmitter to go busy. The requester
// is then acked. The stop bit completes, and a guard time passes before the next grant.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned GUARD_CYCLES   = 5208,
  parameter int unsigned TIMEOUT_CYCLES = 16000
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone, StGuard} state_e;

  localparam logic [CNT_W-1:0] GuardLast   = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ID_W-1:0]  ptr_q;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  pick_next;
  logic [ID_W-1:0]  cand;
  logic [7:0]       req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // First pending requester at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = ptr_q;
    cand       = ptr_q;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      cand = ID_W'((32'(ptr_q) + n) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
    pick_next = ID_W'((32'(pick_id) + 32'd1) % NUM_REQ);
  end

  // Everything outside IDLE counts as busy, including the guard interval.
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Arbitration FSM with registered transmitter handshake, ack pulse and error flag.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ptr_q       <= '0;
      ack         <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      grant_id    <= '0;
      err_timeout <= 1'b0;
    end else begin
      ack <= '0;
      // A timeout firing below overrides this clear.
      if (err_clr) begin
        err_timeout <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (tx_ready && pick_valid) begin
            tx_data  <= req_bytes[pick_id];
            grant_id <= pick_id;
            tx_start <= 1'b1;
            ptr_q    <= pick_next;
            cnt_q    <= '0;
            state_q  <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          // Busy detection wins over a timeout expiring in the same cycle.
          if (!tx_ready) begin
            tx_start <= 1'b0;
            ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
            state_q  <= StWaitDone;
          end else if (cnt_q == TimeoutLast) begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StGuard;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWaitDone: begin
          if (tx_ready) begin
            cnt_q   <= '0;
            state_q <= StGuard;
          end
        end
        StGuard: begin
          if (cnt_q == GuardLast) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
